// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the DataMemory port arbiter: FSM encoding, access modes,
// grant owners and the latched memory command.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_DM   = 2'd2
  } owner_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  mode;
    logic [15:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  // Instruction fetches are always full-word reads.
  function automatic mem_cmd_t if_cmd(logic [15:0] addr);
    mem_cmd_t cmd;
    cmd.we    = 1'b0;
    cmd.mode  = MODE_WORD;
    cmd.addr  = addr;
    cmd.wdata = '0;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_priority.sv
// Winner select between IF and DM requests, with a saturating starvation counter
// that hands IF the port after STARVE_LIMIT consecutive contested DM grants.
module arb_priority
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   if_req,
  input  logic   dm_req,
  input  logic   grant_en,
  output owner_e winner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  always_comb begin
    winner = OWNER_NONE;
    if (if_req && dm_req) begin
      winner = (starve_q == LIMIT) ? OWNER_IF : OWNER_DM;
    end else if (if_req) begin
      winner = OWNER_IF;
    end else if (dm_req) begin
      winner = OWNER_DM;
    end
  end

  // Only counts DM grants that actually made a pending fetch wait.
  always_comb begin
    starve_d = starve_q;
    if (grant_en) begin
      if (winner == OWNER_IF) begin
        starve_d = '0;
      end else if (winner == OWNER_DM) begin
        if (!if_req) begin
          starve_d = '0;
        end else if (starve_q != LIMIT) begin
          starve_d = starve_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported DataMemory between instruction fetch and load/store:
// grant, issue one command, wait the read latency, capture, then a one-cycle ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_mode,
  input  logic [15:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic [15:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [1:0]  mem_mode,
  output logic        mem_wn,
  output logic        mem_rd,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  logic [1:0]  state_q, state_d;
  owner_e      owner_q, owner_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic [2:0]  wait_q, wait_d;
  logic        rd_q, rd_d;
  logic        wn_q, wn_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        busy_q, busy_d;
  owner_e      winner;

  arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb_priority (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .grant_en (state_q == ST_IDLE),
    .winner   (winner)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cmd_d      = cmd_q;
    wait_d     = wait_q;
    rd_d       = 1'b0;
    wn_d       = 1'b0;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (winner != OWNER_NONE) begin
          owner_d = winner;
          if (winner == OWNER_IF) begin
            cmd_d = if_cmd(if_addr);
          end else begin
            cmd_d.we    = dm_we;
            cmd_d.mode  = dm_mode;
            cmd_d.addr  = dm_addr;
            cmd_d.wdata = dm_wdata;
          end
          // Strobes are registered, so they are raised on the edge entering ISSUE.
          rd_d    = !cmd_d.we;
          wn_d    = cmd_d.we;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_q.we) begin
          state_d  = ST_ACK;
          if_ack_d = (owner_q == OWNER_IF);
          dm_ack_d = (owner_q == OWNER_DM);
        end else begin
          state_d = ST_WAIT;
          wait_d  = 3'(MEM_LATENCY);
        end
      end
      ST_WAIT: begin
        wait_d = wait_q - 3'd1;
        if (wait_q == 3'd1) begin
          state_d  = ST_ACK;
          if_ack_d = (owner_q == OWNER_IF);
          dm_ack_d = (owner_q == OWNER_DM);
          if (owner_q == OWNER_IF) begin
            if_rdata_d = mem_read_data;
          end else begin
            dm_rdata_d = mem_read_data;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        owner_d = OWNER_NONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWNER_NONE;
      cmd_q      <= '0;
      wait_q     <= '0;
      rd_q       <= 1'b0;
      wn_q       <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cmd_q      <= cmd_d;
      wait_q     <= wait_d;
      rd_q       <= rd_d;
      wn_q       <= wn_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_address    = cmd_q.addr;
  assign mem_write_data = cmd_q.wdata;
  assign mem_mode       = cmd_q.mode;
  assign mem_rd         = rd_q;
  assign mem_wn         = wn_q;
  assign if_ack         = if_ack_q;
  assign dm_ack         = dm_ack_q;
  assign if_rdata       = if_rdata_q;
  assign dm_rdata       = dm_rdata_q;
  assign busy           = busy_q;

endmodule
